cfg_serial_rx: RTL and testbench

// - Chip-side receiver for the 3-wire configuration link (cfg_en, cfg_sclk, cfg_sdata)

---
 rtl/cfg_pkg.sv | 28 ++
 rtl/sync_edge.sv | 31 +++
 rtl/cfg_serial_rx.sv | 128 ++++++++++++
 tb/tb_cfg_serial_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared constants for the configuration link receiver: frame layout, reset
// defaults and receiver state encoding.
package cfg_pkg;

    localparam int FRAME_W  = 57;
    localparam int CNT_W    = 6;

    localparam int B_W      = 16;
    localparam int A_W      = 16;
    localparam int SCALE_W  = 7;
    localparam int MODE_W   = 3;
    localparam int ITER_W   = 15;

    localparam int B_OFS     = 0;
    localparam int A_OFS     = 16;
    localparam int SCALE_OFS = 32;
    localparam int MODE_OFS  = 39;
    localparam int ITER_OFS  = 42;

    localparam logic [FRAME_W-1:0] DEFAULT_CFG =
        {15'h000F, 3'b000, 7'h7F, 16'hB500, 16'h6080};

    typedef enum logic {
        IDLE,
        RECV
    } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one pad input, with rise/fall detection on the
// synchronised value.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_ff;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
            prev    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
            prev    <= sync_ff[STAGES-1];
        end
    end

    assign q    = sync_ff[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/cfg_serial_rx.sv
// Receiver for the 3-wire configuration link: deserialises one LSB-first frame
// per enable window and commits it atomically when the bit count is exact.
module cfg_serial_rx
    import cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_en,
    input  logic                cfg_sclk,
    input  logic                cfg_sdata,
    output logic [B_W-1:0]      cfg_b_start,
    output logic [A_W-1:0]      cfg_a_start,
    output logic [SCALE_W-1:0]  cfg_scale,
    output logic [MODE_W-1:0]   cfg_mode,
    output logic [ITER_W-1:0]   cfg_max_iter,
    output logic                cfg_valid,
    output logic                cfg_error,
    output logic                busy
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

    logic en_q, en_rise, en_fall;
    logic sclk_q_unused, sclk_rise, sclk_fall_unused;
    logic sdata_q, sdata_rise_unused, sdata_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk(clk), .reset(reset), .d(cfg_en),
        .q(en_q), .rise(en_rise), .fall(en_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(cfg_sclk),
        .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk(clk), .reset(reset), .d(cfg_sdata),
        .q(sdata_q), .rise(sdata_rise_unused), .fall(sdata_fall_unused)
    );

    rx_state_t            state;
    logic [FRAME_W-1:0]   shreg, shreg_nx;
    logic [CNT_W-1:0]     count, count_nx;
    logic                 overflow, overflow_nx;
    logic [SYNC_STAGES:0] prime;
    logic                 armed;

    // Shift-in of the current bit, so an en fall in the same cycle sees it
    always_comb begin
        shreg_nx    = shreg;
        count_nx    = count;
        overflow_nx = overflow;
        if (sclk_rise) begin
            if (count == FRAME_CNT) begin
                overflow_nx = 1'b1;
            end else begin
                shreg_nx = {sdata_q, shreg[FRAME_W-1:1]};
                count_nx = count + 1'b1;
            end
        end
    end

    // Only arm once the synchroniser holds real pad samples and en has been seen
    // low, so an en already high at reset release cannot open a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            prime <= '0;
            armed <= 1'b0;
        end else begin
            prime <= {prime[SYNC_STAGES-1:0], 1'b1};
            if (prime[SYNC_STAGES] && !en_q)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            cfg_b_start  <= DEFAULT_CFG[B_OFS +: B_W];
            cfg_a_start  <= DEFAULT_CFG[A_OFS +: A_W];
            cfg_scale    <= DEFAULT_CFG[SCALE_OFS +: SCALE_W];
            cfg_mode     <= DEFAULT_CFG[MODE_OFS +: MODE_W];
            cfg_max_iter <= DEFAULT_CFG[ITER_OFS +: ITER_W];
            cfg_valid    <= 1'b0;
            cfg_error    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            cfg_error <= 1'b0;
            busy      <= en_q;
            case (state)
                IDLE: begin
                    if (en_rise && armed) begin
                        state    <= RECV;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                RECV: begin
                    shreg    <= shreg_nx;
                    count    <= count_nx;
                    overflow <= overflow_nx;
                    if (en_fall) begin
                        state <= IDLE;
                        if (count_nx == FRAME_CNT && !overflow_nx) begin
                            cfg_b_start  <= shreg_nx[B_OFS +: B_W];
                            cfg_a_start  <= shreg_nx[A_OFS +: A_W];
                            cfg_scale    <= shreg_nx[SCALE_OFS +: SCALE_W];
                            cfg_mode     <= shreg_nx[MODE_OFS +: MODE_W];
                            cfg_max_iter <= shreg_nx[ITER_OFS +: ITER_W];
                            cfg_valid    <= 1'b1;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_serial_rx.sv
// Directed bench for cfg_serial_rx: frames are shifted in LSB first from the pad
// side and the committed registers and pulses are compared with hand values.
module tb_cfg_serial_rx;

    logic        clk;
    logic        reset;
    logic        cfg_en;
    logic        cfg_sclk;
    logic        cfg_sdata;
    logic [15:0] cfg_b_start;
    logic [15:0] cfg_a_start;
    logic [6:0]  cfg_scale;
    logic [2:0]  cfg_mode;
    logic [14:0] cfg_max_iter;
    logic        cfg_valid;
    logic        cfg_error;
    logic        busy;
    logic [56:0] cfg_all;

    int n_checks;
    int n_pass;
    int valid_cnt;
    int error_cnt;

    localparam logic [56:0] EXP_DEFAULT = {15'h000F, 3'b000, 7'h7F, 16'hB500, 16'h6080};
    localparam logic [56:0] FRAME_A     = {15'h03FF, 3'b011, 7'h7F, 16'hB500, 16'h6080};
    localparam logic [56:0] FRAME_C     = {15'h1234, 3'b101, 7'h2A, 16'h1357, 16'h9BDF};
    localparam logic [56:0] FRAME_D1    = {15'h7FFF, 3'b110, 7'h00, 16'hBC40, 16'hF3CA};
    localparam logic [56:0] FRAME_D2    = {15'h7FFF, 3'b111, 7'h01, 16'hBC40, 16'hF3CA};
    localparam logic [56:0] FRAME_E     = {15'h0ABC, 3'b010, 7'h55, 16'hDEAD, 16'hBEEF};

    cfg_serial_rx dut (
        .clk(clk), .reset(reset),
        .cfg_en(cfg_en), .cfg_sclk(cfg_sclk), .cfg_sdata(cfg_sdata),
        .cfg_b_start(cfg_b_start), .cfg_a_start(cfg_a_start),
        .cfg_scale(cfg_scale), .cfg_mode(cfg_mode), .cfg_max_iter(cfg_max_iter),
        .cfg_valid(cfg_valid), .cfg_error(cfg_error), .busy(busy)
    );

    assign cfg_all = {cfg_max_iter, cfg_mode, cfg_scale, cfg_a_start, cfg_b_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_valid) valid_cnt++;
        if (cfg_error) error_cnt++;
    end

    // Pad-side frame: sdata changes with the sclk fall, sclk high/low one clk each
    task automatic drive_frame(input logic [63:0] data, input int nbits, input bit coincident);
        cfg_en = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            cfg_sdata = data[i];
            cfg_sclk  = 1'b0;
            @(negedge clk);
            cfg_sclk = 1'b1;
            if (coincident && i == nbits - 1) cfg_en = 1'b0;
            @(negedge clk);
        end
        cfg_sclk = 1'b0;
        cfg_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_en = 1'b0; cfg_sclk = 1'b0; cfg_sdata = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cfg_all !== EXP_DEFAULT)
            $display("[TB] FAIL reset_cfg: got %h expected %h", cfg_all, EXP_DEFAULT);
        else n_pass++;
        n_checks++;
        if ({cfg_valid, cfg_error, busy} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b expected 000", {cfg_valid, cfg_error, busy});
        else n_pass++;
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int v0, e0;
        bit busy_seen;
        v0 = valid_cnt; e0 = error_cnt;
        cfg_en = 1'b1;
        repeat (4) @(negedge clk);
        busy_seen = busy;
        cfg_en = 1'b0;
        drive_frame({7'd0, FRAME_A}, 57, 1'b0);
        n_checks++;
        if (busy_seen !== 1'b1)
            $display("[TB] FAIL busy_during_frame: got %b expected 1", busy_seen);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cfg_valid !== 1'b0 || cfg_all !== EXP_DEFAULT)
            $display("[TB] FAIL latency_early: valid %b cfg %h expected 0 / %h", cfg_valid, cfg_all, EXP_DEFAULT);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (cfg_valid !== 1'b1)
            $display("[TB] FAIL latency_valid: got %b expected 1", cfg_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (cfg_valid !== 1'b0)
            $display("[TB] FAIL valid_one_cycle: got %b expected 0", cfg_valid);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cfg_max_iter !== 15'h03FF || cfg_mode !== 3'd3 || cfg_scale !== 7'h7F)
            $display("[TB] FAIL frame1_fields: iter %h mode %h scale %h expected 03ff 3 7f", cfg_max_iter, cfg_mode, cfg_scale);
        else n_pass++;
        n_checks++;
        if (cfg_a_start !== 16'hB500 || cfg_b_start !== 16'h6080)
            $display("[TB] FAIL frame1_ab: a %h b %h expected b500 6080", cfg_a_start, cfg_b_start);
        else n_pass++;
        n_checks++;
        if (valid_cnt - v0 !== 1 || error_cnt - e0 !== 0 || busy !== 1'b0)
            $display("[TB] FAIL frame1_pulses: valid %0d error %0d busy %b expected 1 0 0", valid_cnt - v0, error_cnt - e0, busy);
        else n_pass++;
    endtask

    task automatic test_bad_length();
        int v0, e0;
        v0 = valid_cnt; e0 = error_cnt;
        drive_frame({7'd0, FRAME_C}, 56, 1'b0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (error_cnt - e0 !== 1 || valid_cnt - v0 !== 0)
            $display("[TB] FAIL short_frame_pulses: error %0d valid %0d expected 1 0", error_cnt - e0, valid_cnt - v0);
        else n_pass++;
        n_checks++;
        if (cfg_all !== FRAME_A)
            $display("[TB] FAIL short_frame_hold: got %h expected %h", cfg_all, FRAME_A);
        else n_pass++;
        drive_frame({6'd0, 1'b1, FRAME_C}, 58, 1'b0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (error_cnt - e0 !== 2 || valid_cnt - v0 !== 0)
            $display("[TB] FAIL long_frame_pulses: error %0d valid %0d expected 2 0", error_cnt - e0, valid_cnt - v0);
        else n_pass++;
        n_checks++;
        if (cfg_all !== FRAME_A)
            $display("[TB] FAIL long_frame_hold: got %h expected %h", cfg_all, FRAME_A);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        cfg_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            cfg_sdata = FRAME_C[i]; cfg_sclk = 1'b0;
            @(negedge clk);
            cfg_sclk = 1'b1;
            @(negedge clk);
        end
        cfg_sclk = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cfg_all !== EXP_DEFAULT || busy !== 1'b0)
            $display("[TB] FAIL mid_reset: cfg %h busy %b expected %h 0", cfg_all, busy, EXP_DEFAULT);
        else n_pass++;
        // en is still high at release: the held-high window must not be taken as a frame
        reset = 1'b0;
        v0 = valid_cnt; e0 = error_cnt;
        repeat (4) @(negedge clk);
        drive_frame({7'd0, FRAME_C}, 57, 1'b0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (valid_cnt - v0 !== 0 || error_cnt - e0 !== 0 || cfg_all !== EXP_DEFAULT)
            $display("[TB] FAIL no_fresh_rise: valid %0d error %0d cfg %h expected 0 0 %h", valid_cnt - v0, error_cnt - e0, cfg_all, EXP_DEFAULT);
        else n_pass++;
        drive_frame({7'd0, FRAME_C}, 57, 1'b0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (valid_cnt - v0 !== 1 || cfg_all !== FRAME_C)
            $display("[TB] FAIL after_reset_frame: valid %0d cfg %h expected 1 %h", valid_cnt - v0, cfg_all, FRAME_C);
        else n_pass++;
    endtask

    task automatic test_sclk_idle();
        int v0, e0;
        v0 = valid_cnt; e0 = error_cnt;
        for (int i = 0; i < 20; i++) begin
            cfg_sdata = i[0]; cfg_sclk = 1'b1;
            @(negedge clk);
            cfg_sclk = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (valid_cnt - v0 !== 0 || error_cnt - e0 !== 0 || busy !== 1'b0 || cfg_all !== FRAME_C)
            $display("[TB] FAIL idle_sclk: valid %0d error %0d busy %b cfg %h expected 0 0 0 %h", valid_cnt - v0, error_cnt - e0, busy, cfg_all, FRAME_C);
        else n_pass++;
        drive_frame({7'd0, FRAME_A}, 57, 1'b0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (valid_cnt - v0 !== 1 || error_cnt - e0 !== 0 || cfg_all !== FRAME_A)
            $display("[TB] FAIL idle_then_frame: valid %0d error %0d cfg %h expected 1 0 %h", valid_cnt - v0, error_cnt - e0, cfg_all, FRAME_A);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int v0, e0;
        v0 = valid_cnt; e0 = error_cnt;
        drive_frame({7'd0, FRAME_D1}, 57, 1'b0);
        @(negedge clk);
        drive_frame({7'd0, FRAME_D2}, 57, 1'b0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (valid_cnt - v0 !== 2 || error_cnt - e0 !== 0)
            $display("[TB] FAIL b2b_pulses: valid %0d error %0d expected 2 0", valid_cnt - v0, error_cnt - e0);
        else n_pass++;
        n_checks++;
        if (cfg_mode !== 3'd7 || cfg_scale !== 7'h01 || cfg_all !== FRAME_D2)
            $display("[TB] FAIL b2b_last_wins: mode %h scale %h cfg %h expected 7 01 %h", cfg_mode, cfg_scale, cfg_all, FRAME_D2);
        else n_pass++;
    endtask

    task automatic test_coincident_edge();
        int v0, e0;
        v0 = valid_cnt; e0 = error_cnt;
        drive_frame({7'd0, FRAME_E}, 57, 1'b1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (valid_cnt - v0 !== 1 || error_cnt - e0 !== 0)
            $display("[TB] FAIL coincident_pulses: valid %0d error %0d expected 1 0", valid_cnt - v0, error_cnt - e0);
        else n_pass++;
        n_checks++;
        if (cfg_all !== FRAME_E)
            $display("[TB] FAIL coincident_cfg: got %h expected %h", cfg_all, FRAME_E);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; valid_cnt = 0; error_cnt = 0;
        test_reset();
        test_good_frame();
        test_bad_length();
        test_reset_mid_frame();
        test_sclk_idle();
        test_back_to_back();
        test_coincident_edge();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
